// File: rtl/rsa_host_ctrl.sv
// Host-side initiator for the RSA engine word stream: serialises key/modulus/message
// into select-tagged 32-bit bursts and gathers the variable-length response.
module rsa_host_ctrl #(
  parameter int KEY_WIDTH = 256,
  parameter int TIMEOUT   = 1024
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               start,
  input  logic                               reload_key,
  input  logic [KEY_WIDTH-1:0]               key_in,
  input  logic [KEY_WIDTH-1:0]               mod_in,
  input  logic [KEY_WIDTH-1:0]               msg_in,
  output logic                               busy,
  output logic                               done,
  output logic                               timeout_err,
  output logic [KEY_WIDTH-1:0]               result,
  output logic [$clog2(KEY_WIDTH/32+1)-1:0]  result_words,
  output logic                               dut_en,
  output logic                               dut_valid_in,
  output logic [1:0]                         dut_select,
  output logic [31:0]                        dut_data_in,
  input  logic [31:0]                        dut_data_out,
  input  logic                               dut_valid_out
);

  localparam int N   = KEY_WIDTH / 32;
  localparam int WCW = (N > 1) ? $clog2(N) : 1;
  localparam int RWW = $clog2(N + 1);
  localparam int TCW = $clog2(TIMEOUT + 1);

  localparam logic [1:0] SEL_KEY = 2'b10;
  localparam logic [1:0] SEL_MOD = 2'b01;
  localparam logic [1:0] SEL_MSG = 2'b11;

  typedef enum logic [3:0] {
    IDLE, SEND_KEY, GAP_K, SEND_MOD, GAP_M, SEND_MSG, GAP_D, WAIT_RESP, RECV, FIN
  } state_t;

  state_t                 state;
  logic [KEY_WIDTH-1:0]   key_r;
  logic [KEY_WIDTH-1:0]   mod_r;
  logic [KEY_WIDTH-1:0]   msg_r;
  logic [WCW-1:0]         wcnt;
  logic [TCW-1:0]         tcnt;

  logic                   last_word;
  logic [WCW-1:0]         next_idx;
  logic                   tmo_hit;
  logic                   room;

  function automatic logic [31:0] word_of(input logic [KEY_WIDTH-1:0] op,
                                          input logic [WCW-1:0] idx);
    return op[int'(idx)*32 +: 32];
  endfunction

  assign dut_en    = rst_n;
  assign last_word = (wcnt == WCW'(N - 1));
  assign next_idx  = wcnt + WCW'(1);
  assign tmo_hit   = (tcnt == TCW'(TIMEOUT - 1));
  assign room      = (result_words < RWW'(N));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      key_r        <= '0;
      mod_r        <= '0;
      msg_r        <= '0;
      wcnt         <= '0;
      tcnt         <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      timeout_err  <= 1'b0;
      result       <= '0;
      result_words <= '0;
      dut_valid_in <= 1'b0;
      dut_select   <= 2'b00;
      dut_data_in  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            key_r        <= key_in;
            mod_r        <= mod_in;
            msg_r        <= msg_in;
            result       <= '0;
            result_words <= '0;
            timeout_err  <= 1'b0;
            busy         <= 1'b1;
            wcnt         <= '0;
            tcnt         <= '0;
            dut_valid_in <= 1'b1;
            // First word goes out on the cycle after acceptance, aligned with the SEND state.
            if (reload_key) begin
              state       <= SEND_KEY;
              dut_select  <= SEL_KEY;
              dut_data_in <= key_in[31:0];
            end else begin
              state       <= SEND_MSG;
              dut_select  <= SEL_MSG;
              dut_data_in <= msg_in[31:0];
            end
          end
        end
        SEND_KEY, SEND_MOD, SEND_MSG: begin
          if (last_word) begin
            dut_valid_in <= 1'b0;
            dut_select   <= 2'b00;
            dut_data_in  <= '0;
            state        <= (state == SEND_KEY) ? GAP_K :
                            (state == SEND_MOD) ? GAP_M : GAP_D;
          end else begin
            wcnt        <= next_idx;
            dut_data_in <= (state == SEND_KEY) ? word_of(key_r, next_idx) :
                           (state == SEND_MOD) ? word_of(mod_r, next_idx) :
                                                 word_of(msg_r, next_idx);
          end
        end
        GAP_K: begin
          state        <= SEND_MOD;
          wcnt         <= '0;
          dut_valid_in <= 1'b1;
          dut_select   <= SEL_MOD;
          dut_data_in  <= mod_r[31:0];
        end
        GAP_M: begin
          state        <= SEND_MSG;
          wcnt         <= '0;
          dut_valid_in <= 1'b1;
          dut_select   <= SEL_MSG;
          dut_data_in  <= msg_r[31:0];
        end
        GAP_D: begin
          state <= WAIT_RESP;
          tcnt  <= '0;
        end
        WAIT_RESP: begin
          if (tmo_hit) begin
            state       <= FIN;
            done        <= 1'b1;
            busy        <= 1'b0;
            timeout_err <= 1'b1;
          end else begin
            tcnt <= tcnt + TCW'(1);
            if (dut_valid_out) begin
              result[31:0] <= dut_data_out;
              result_words <= RWW'(1);
              state        <= RECV;
            end
          end
        end
        RECV: begin
          if (tmo_hit) begin
            state       <= FIN;
            done        <= 1'b1;
            busy        <= 1'b0;
            timeout_err <= 1'b1;
          end else begin
            tcnt <= tcnt + TCW'(1);
            if (dut_valid_out) begin
              // Surplus words beyond the result width are discarded.
              if (room) begin
                result[int'(result_words)*32 +: 32] <= dut_data_out;
                result_words <= result_words + RWW'(1);
              end
            end else begin
              state <= FIN;
              done  <= 1'b1;
              busy  <= 1'b0;
            end
          end
        end
        FIN: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rsa_host_ctrl.sv
// Scoreboard bench for rsa_host_ctrl (KEY_WIDTH=64, TIMEOUT=16) with a scripted engine response.
module tb_rsa_host_ctrl;

  localparam int KW = 64;
  localparam int N  = KW / 32;
  localparam int TO = 16;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic          reload_key;
  logic [KW-1:0] key_in;
  logic [KW-1:0] mod_in;
  logic [KW-1:0] msg_in;
  logic          busy;
  logic          done;
  logic          timeout_err;
  logic [KW-1:0] result;
  logic [1:0]    result_words;
  logic          dut_en;
  logic          dut_valid_in;
  logic [1:0]    dut_select;
  logic [31:0]   dut_data_in;
  logic [31:0]   dut_data_out;
  logic          dut_valid_out;

  rsa_host_ctrl #(.KEY_WIDTH(KW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .reload_key(reload_key),
    .key_in(key_in), .mod_in(mod_in), .msg_in(msg_in),
    .busy(busy), .done(done), .timeout_err(timeout_err),
    .result(result), .result_words(result_words),
    .dut_en(dut_en), .dut_valid_in(dut_valid_in), .dut_select(dut_select),
    .dut_data_in(dut_data_in), .dut_data_out(dut_data_out),
    .dut_valid_out(dut_valid_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef logic [34:0] beat_t;  // {valid, select, data}
  typedef struct packed {
    logic [KW-1:0] res;
    logic [1:0]    words;
    logic          terr;
  } resp_t;

  beat_t exp_burst[$];
  resp_t exp_res[$];
  int    checks = 0;
  int    errors = 0;
  int    done_seen = 0;
  int    cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Beat monitor: every driven word, and the gap after each field, against the expected stream.
  initial begin
    beat_t b;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (dut_valid_in) begin
          if (exp_burst.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_beat: got sel %0b data %0h expected none", dut_select, dut_data_in);
          end else begin
            b = exp_burst.pop_front();
            chk("beat", {29'd0, dut_valid_in, dut_select, dut_data_in}, {29'd0, b});
          end
        end else if (exp_burst.size() != 0 && exp_burst[0][34] == 1'b0) begin
          b = exp_burst.pop_front();
          chk("gap", {61'd0, dut_valid_in, dut_select}, {61'd0, b[34:32]});
        end
      end
    end
  end

  // Result monitor: pops one expected response per done pulse.
  initial begin
    resp_t r;
    forever begin
      @(negedge clk);
      if (rst_n && done) begin
        done_seen++;
        if (exp_res.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_done: got done with result %0h expected no done", result);
        end else begin
          r = exp_res.pop_front();
          chk("result", result, r.res);
          chk("result_words", 64'(result_words), 64'(r.words));
          chk("timeout_err", 64'(timeout_err), 64'(r.terr));
          chk("busy_at_done", 64'(busy), 64'd0);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  task automatic push_bursts(input bit reload, input logic [KW-1:0] k, m, d);
    if (reload) begin
      for (int i = 0; i < N; i++) exp_burst.push_back({1'b1, 2'b10, k[32*i +: 32]});
      exp_burst.push_back({1'b0, 2'b00, 32'h0});
      for (int i = 0; i < N; i++) exp_burst.push_back({1'b1, 2'b01, m[32*i +: 32]});
      exp_burst.push_back({1'b0, 2'b00, 32'h0});
    end
    for (int i = 0; i < N; i++) exp_burst.push_back({1'b1, 2'b11, d[32*i +: 32]});
    exp_burst.push_back({1'b0, 2'b00, 32'h0});
  endtask

  task automatic issue_start(input bit reload, input logic [KW-1:0] k, m, d);
    @(posedge clk); #1;
    start = 1'b1; reload_key = reload; key_in = k; mod_in = m; msg_in = d;
    @(posedge clk); #1;
    start = 1'b0; reload_key = ~reload; key_in = ~k; mod_in = ~m; msg_in = ~d;
    chk("busy_set", 64'(busy), 64'd1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd0);
    chk({tag, "_terr"}, 64'(timeout_err), 64'd0);
    chk({tag, "_result"}, result, 64'd0);
    chk({tag, "_rwords"}, 64'(result_words), 64'd0);
    chk({tag, "_en"}, 64'(dut_en), 64'd0);
    chk({tag, "_vin"}, 64'(dut_valid_in), 64'd0);
    chk({tag, "_sel"}, 64'(dut_select), 64'd0);
    chk({tag, "_din"}, 64'(dut_data_in), 64'd0);
  endtask

  task automatic run_txn(input bit reload, input logic [KW-1:0] k, m, d,
                         input logic [31:0] r0, r1, r2, input int nresp,
                         input logic [KW-1:0] eres, input logic [1:0] ewords,
                         input bit eterr, input bit poke);
    logic [31:0] rw [3];
    bit seen_d, ok, poking, poked;
    int g;
    rw[0] = r0; rw[1] = r1; rw[2] = r2;
    push_bursts(reload, k, m, d);
    exp_res.push_back(resp_t'{res: eres, words: ewords, terr: eterr});
    issue_start(reload, k, m, d);
    seen_d = 0; ok = 0; poking = 0; poked = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (poking) begin start = 1'b0; poking = 0; end
      if (poke && !poked && dut_valid_in && dut_select == 2'b01) begin
        start = 1'b1; reload_key = 1'b1; poking = 1; poked = 1;
      end
      if (dut_valid_in && dut_select == 2'b11) seen_d = 1;
      else if (seen_d && !dut_valid_in) begin ok = 1; break; end
    end
    chk("burst_end", 64'(ok), 64'd1);
    chk("busy_mid", 64'(busy), 64'd1);
    g = cyc;
    if (nresp > 0) begin
      repeat (2) @(posedge clk);
      for (int i = 0; i < nresp; i++) begin
        #1; dut_valid_out = 1'b1; dut_data_out = rw[i];
        @(posedge clk);
      end
      #1; dut_valid_out = 1'b0; dut_data_out = 32'hDEAD_BEEF;
    end
    ok = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (done) begin ok = 1; break; end
    end
    chk("done_arrives", 64'(ok), 64'd1);
    if (eterr) chk("timeout_latency", 64'(cyc - g), 64'd17);
    repeat (3) @(negedge clk);
    chk("result_hold", result, eres);
    chk("terr_hold", 64'(timeout_err), 64'(eterr));
    chk("idle_busy", 64'(busy), 64'd0);
  endtask

  initial begin
    bit ok;
    rst_n = 1'b0; start = 1'b0; reload_key = 1'b0;
    key_in = '0; mod_in = '0; msg_in = '0;
    dut_valid_out = 1'b0; dut_data_out = 32'hDEAD_BEEF;
    repeat (2) @(posedge clk); #1;
    chk_reset_outputs("reset");
    rst_n = 1'b1;
    #1 chk("en_after_reset", 64'(dut_en), 64'd1);

    // 5^3 mod 33 = 26
    run_txn(1, 64'd3, 64'd33, 64'd5, 32'd26, 32'd0, 32'd0, 1, 64'd26, 2'd1, 0, 0);
    // message only: 4^3 mod 33 = 31
    run_txn(0, 64'd3, 64'd33, 64'd4, 32'd31, 32'd0, 32'd0, 1, 64'd31, 2'd1, 0, 0);
    // two-word response, LSW first: 2^40
    run_txn(1, 64'd1, 64'h8000_0000_0000_0001, 64'h0000_0100_0000_0000,
            32'h0, 32'h100, 32'h0, 2, 64'h0000_0100_0000_0000, 2'd2, 0, 0);
    // no response: timeout after 16 cycles in WAIT_RESP
    run_txn(0, 64'd3, 64'd33, 64'd7, 32'd0, 32'd0, 32'd0, 0, 64'd0, 2'd0, 1, 0);
    // three response words into a two-word result: third dropped, count saturates
    run_txn(0, 64'd3, 64'd33, 64'd9, 32'd11, 32'd22, 32'd33, 3,
            64'h0000_0016_0000_000B, 2'd2, 0, 0);
    // start pulsed during the modulus burst is ignored
    run_txn(1, 64'd3, 64'd33, 64'd5, 32'd26, 32'd0, 32'd0, 1, 64'd26, 2'd1, 0, 1);

    // reset during the modulus burst: asynchronous abort, no done
    push_bursts(1, 64'd3, 64'd33, 64'd5);
    issue_start(1, 64'd3, 64'd33, 64'd5);
    ok = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (dut_valid_in && dut_select == 2'b01) begin ok = 1; break; end
    end
    chk("reach_send_mod", 64'(ok), 64'd1);
    #2 rst_n = 1'b0;
    exp_burst.delete();
    #1 chk_reset_outputs("async_rst");
    repeat (2) @(posedge clk); #1;
    chk("no_done_in_rst", 64'(done), 64'd0);
    rst_n = 1'b1;
    run_txn(1, 64'd3, 64'd33, 64'd5, 32'd26, 32'd0, 32'd0, 1, 64'd26, 2'd1, 0, 0);

    repeat (5) @(posedge clk);
    chk("done_count", 64'(done_seen), 64'd7);
    chk("resp_queue_empty", 64'(exp_res.size()), 64'd0);
    chk("beat_queue_empty", 64'(exp_burst.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rsa_host_ctrl.md
Name: rsa_host_ctrl

Overview:
Host-side initiator for the RSA encrypter/decrypter word-stream interface. It takes a wide key, modulus and message from a parallel host port. It serialises them into 32-bit select-tagged bursts on the engine's input side, then collects the variable-length result stream into a wide result register. It sits between a CPU/test register block and the encrypter_decrypter engine.

Parameters:
KEY_WIDTH, 256, operand width in bits; must be a multiple of 32; N = KEY_WIDTH/32 words per field.
TIMEOUT, 1024, maximum cycles spent in WAIT_RESP/RECV before the transaction is aborted.

Ports:
clk  in  1  system clock; all logic on rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle request; sampled in IDLE only
reload_key  in  1  sampled with start; 1 = send key and modulus before the message, 0 = send message only
key_in  in  KEY_WIDTH  exponent, sampled on accepted start
mod_in  in  KEY_WIDTH  modulus, sampled on accepted start
msg_in  in  KEY_WIDTH  plaintext/ciphertext, sampled on accepted start
busy  out  1  high from the cycle after an accepted start until done
done  out  1  one-cycle pulse at transaction end
timeout_err  out  1  valid with done; 1 = response not completed within TIMEOUT
result  out  KEY_WIDTH  collected response, zero-extended; held until the next accepted start
result_words  out  $clog2(N+1)  number of response words received
dut_en  out  1  engine enable
dut_valid_in  out  1  word strobe to the engine
dut_select  out  2  field tag: 2'b10 key, 2'b01 modulus, 2'b11 data
dut_data_in  out  32  word to the engine
dut_data_out  in  32  response word
dut_valid_out  in  1  response word strobe

Behaviour:
- Reset (asynchronous): busy=0, done=0, timeout_err=0, result=0, result_words=0, dut_en=0, dut_valid_in=0, dut_select=0, dut_data_in=0. FSM goes to IDLE. Operand registers and counters are cleared.
- dut_en=1 whenever rst_n is high.
- FSM states: IDLE, SEND_KEY, GAP_K, SEND_MOD, GAP_M, SEND_MSG, GAP_D, WAIT_RESP, RECV, FIN.
- IDLE: on start, latch the three operands and reload_key, clear result and result_words, and set busy. Next state is SEND_KEY if reload_key=1, else SEND_MSG.
- SEND_x: exactly N consecutive cycles with dut_valid_in=1. dut_select is held at the field tag. dut_data_in = word i of the operand, bits [32i+31:32i], for i = 0..N-1, least-significant word first. A 3-bit/clog2 word counter tracks i.
- GAP_x: one cycle with dut_valid_in=0 and dut_select=0. This falling edge of dut_valid_in terminates the field; every field is one contiguous burst. Transitions: GAP_K -> SEND_MOD, GAP_M -> SEND_MSG, GAP_D -> WAIT_RESP.
- Field order is always key, modulus, message. The message is always the last field, because the engine starts its computation on the falling edge after the data field.
- WAIT_RESP: on the first rising edge with dut_valid_out=1, store dut_data_out into result word 0, set result_words=1, and go to RECV.
- RECV: while dut_valid_out=1, store the word at index result_words and increment result_words. The first cycle with dut_valid_out=0 goes to FIN.
- Words beyond N are dropped and result_words saturates at N. dut_data_out is ignored whenever dut_valid_out=0, since it may be X/Z.
- Timeout: a cycle counter runs in WAIT_RESP and RECV. When it reaches TIMEOUT, go to FIN with timeout_err=1. result keeps the words received so far.
- FIN: done=1 for one cycle, busy=0, then return to IDLE. timeout_err holds until the next accepted start.
- start while busy is ignored, with no queuing. start in the same cycle as FIN is ignored; it is accepted only from IDLE.
- Reset mid-transaction aborts immediately with no done pulse. Dropping dut_valid_in may end a partial field at the engine; software must re-issue with reload_key=1 after reset.
- Latency with reload_key=1: first response sample no earlier than 3N+3 cycles after start.

Test Plan:
1. KEY_WIDTH=64. key=3, mod=33, msg=5, reload_key=1 -> bursts 10:{3,0}, 01:{33,0}, 11:{5,0}, each followed by a 1-cycle gap; result=26, result_words=1, timeout_err=0, one done pulse.
2. After test 1, reload_key=0, msg=4 -> only the 11 burst is driven; result=31 (64 mod 33).
3. KEY_WIDTH=64. key=1, mod=2^63+1, msg=2^40 -> result=2^40, result_words=2, words captured in LSW-first order.
4. dut_valid_out tied 0, TIMEOUT=16 -> done at 16 cycles after entering WAIT_RESP, timeout_err=1, result=0, result_words=0.
5. start pulsed again during SEND_MOD -> ignored; exactly one done; operand words unchanged mid-burst.
6. rst_n low during SEND_MOD -> all outputs reach reset values asynchronously with no done; the next start with reload_key=1 completes with the result from test 1.
